// File: rtl/text_cell_fetcher.sv
// Text-mode cell sequencer: cell-coordinate scan counters, one text RAM read per pixel, palette resolve.
// Latency 3 cycles from i_pixel_en to o_valid at full throughput; there is no backpressure path.
module text_cell_fetcher #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int ADDR_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_line_end,
  input  logic              i_pixel_en,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_ram_rd,
  output logic [ADDR_W-1:0] o_ram_addr,
  input  logic [15:0]       i_ram_data,
  input  logic              i_pal_we,
  input  logic [3:0]        i_pal_addr,
  input  logic [11:0]       i_pal_data,
  output logic              o_valid,
  output logic [7:0]        o_char,
  output logic [2:0]        o_row,
  output logic [2:0]        o_column,
  output logic [11:0]       o_fg_color,
  output logic [11:0]       o_bg_color
);

  localparam int CC_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [2:0]        pix_col;
  logic [2:0]        pix_row;
  logic [CC_W-1:0]   cell_col;
  logic [CR_W-1:0]   cell_row;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] base;
  logic              armed;
  logic              pix_go;
  logic [ADDR_W-1:0] cell_addr;

  logic [2:0]        s1_row;
  logic [2:0]        s1_col;
  logic              s2_vld;
  logic [2:0]        s2_row;
  logic [2:0]        s2_col;

  logic [11:0]       pal [16];

  // Pixels are ignored after reset until a frame start has positioned the counters.
  assign pix_go    = i_pixel_en & armed;
  assign cell_addr = row_base + ADDR_W'(cell_col);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_col  <= '0;
      pix_row  <= '0;
      cell_col <= '0;
      cell_row <= '0;
      row_base <= '0;
      base     <= '0;
      armed    <= 1'b0;
    end else begin
      if (i_frame_start) begin
        base     <= i_base_addr;
        row_base <= i_base_addr;
        pix_col  <= '0;
        pix_row  <= '0;
        cell_col <= '0;
        cell_row <= '0;
        armed    <= 1'b1;
      end else if (i_line_end) begin
        pix_col <= '0;
        cell_col <= '0;
        pix_row <= pix_row + 3'd1;
        if (pix_row == 3'd7) begin
          if (cell_row == CR_W'(ROWS - 1)) begin
            cell_row <= '0;
            row_base <= base;
          end else begin
            cell_row <= cell_row + CR_W'(1);
            row_base <= row_base + ADDR_W'(COLS);
          end
        end
      end else if (pix_go) begin
        pix_col <= pix_col + 3'd1;
        if (pix_col == 3'd7) begin
          if (cell_col == CC_W'(COLS - 1)) begin
            cell_col <= '0;
          end else begin
            cell_col <= cell_col + CC_W'(1);
          end
        end
      end
    end
  end

  // Read stage, RAM data stage, then registered resolve into the output stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ram_rd   <= 1'b0;
      o_ram_addr <= '0;
      s1_row     <= '0;
      s1_col     <= '0;
      s2_vld     <= 1'b0;
      s2_row     <= '0;
      s2_col     <= '0;
      o_valid    <= 1'b0;
      o_char     <= '0;
      o_row      <= '0;
      o_column   <= '0;
      o_fg_color <= '0;
      o_bg_color <= '0;
    end else begin
      o_ram_rd <= pix_go;
      if (pix_go) begin
        o_ram_addr <= cell_addr;
        s1_row     <= pix_row;
        s1_col     <= pix_col;
      end
      s2_vld <= o_ram_rd;
      if (o_ram_rd) begin
        s2_row <= s1_row;
        s2_col <= s1_col;
      end
      o_valid <= s2_vld;
      if (s2_vld) begin
        o_char     <= i_ram_data[15:8];
        o_fg_color <= pal[i_ram_data[7:4]];
        o_bg_color <= pal[i_ram_data[3:0]];
        o_row      <= s2_row;
        o_column   <= s2_col;
      end
    end
  end

  // Lookups read the register array directly, so a same-cycle write is seen one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 16; k++) begin
        pal[k] <= {3{4'(k)}};
      end
    end else if (i_pal_we) begin
      pal[i_pal_addr] <= i_pal_data;
    end
  end

endmodule

// File: tb/tb_text_cell_fetcher.sv
// Randomized bench for text_cell_fetcher against a scan-position reference model.
module tb_text_cell_fetcher;
  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int AW   = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          line_end = 1'b0;
  logic          pixel_en = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          ram_rd;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_data = '0;
  logic          pal_we = 1'b0;
  logic [3:0]    pal_addr = '0;
  logic [11:0]   pal_data = '0;
  logic          valid;
  logic [7:0]    char_code;
  logic [2:0]    row;
  logic [2:0]    column;
  logic [11:0]   fg_color;
  logic [11:0]   bg_color;

  text_cell_fetcher #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_line_end(line_end),
    .i_pixel_en(pixel_en), .i_base_addr(base_addr), .o_ram_rd(ram_rd), .o_ram_addr(ram_addr),
    .i_ram_data(ram_data), .i_pal_we(pal_we), .i_pal_addr(pal_addr), .i_pal_data(pal_data),
    .o_valid(valid), .o_char(char_code), .o_row(row), .o_column(column),
    .o_fg_color(fg_color), .o_bg_color(bg_color)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [1 << AW];
  always @(posedge clk) ram_data <= ram[ram_addr];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan position as line/pixel counts since frame start.
  typedef struct {
    bit            v;
    logic [AW-1:0] addr;
    logic [2:0]    r;
    logic [2:0]    c;
  } pix_t;

  int            ln, px;
  logic [AW-1:0] m_base;
  bit            m_armed;
  logic [11:0]   mpal [16];
  pix_t          q1, q2;
  logic          e_valid, e_rd;
  logic [AW-1:0] e_addr;
  logic [7:0]    e_char;
  logic [2:0]    e_row, e_col;
  logic [11:0]   e_fg, e_bg;

  task automatic model_reset();
    ln = 0; px = 0; m_base = '0; m_armed = 0;
    for (int k = 0; k < 16; k++) mpal[k] = {3{4'(k)}};
    q1.v = 0; q2.v = 0;
    e_valid = 0; e_rd = 0; e_addr = '0; e_char = '0;
    e_row = '0; e_col = '0; e_fg = '0; e_bg = '0;
  endtask

  task automatic model_edge();
    pix_t        cur;
    logic [15:0] w;
    cur.v    = pixel_en && m_armed;
    cur.addr = AW'((int'(m_base) + ((ln / 8) % ROWS) * COLS + (px / 8) % COLS) % (1 << AW));
    cur.r    = 3'(ln % 8);
    cur.c    = 3'(px % 8);
    if (q2.v) begin
      w = ram[q2.addr];
      e_valid = 1; e_char = w[15:8]; e_fg = mpal[w[7:4]]; e_bg = mpal[w[3:0]];
      e_row = q2.r; e_col = q2.c;
    end else begin
      e_valid = 0;
    end
    e_rd = cur.v;
    if (cur.v) e_addr = cur.addr;
    q2 = q1;
    q1 = cur;
    if (pal_we) mpal[pal_addr] = pal_data;
    if (frame_start) begin
      m_base = base_addr; ln = 0; px = 0; m_armed = 1;
    end else if (line_end) begin
      px = 0; ln = (ln + 1) % (ROWS * 8);
    end else if (pixel_en && m_armed) begin
      px = (px + 1) % (COLS * 8);
    end
  endtask

  task automatic check_outputs();
    check("valid", valid, e_valid);
    check("ram_rd", ram_rd, e_rd);
    if (e_rd) check("ram_addr", ram_addr, e_addr);
    check("char", char_code, e_char);
    check("row", row, e_row);
    check("column", column, e_col);
    check("fg", fg_color, e_fg);
    check("bg", bg_color, e_bg);
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) model_edge(); else model_reset();
    #1;
    check_outputs();
  endtask

  task automatic px_run(input int n);
    pixel_en = 1;
    repeat (n) cyc();
    pixel_en = 0;
  endtask

  task automatic line_pulse();
    line_end = 1;
    cyc();
    line_end = 0;
  endtask

  task automatic frame(input logic [AW-1:0] b);
    frame_start = 1;
    base_addr = b;
    cyc();
    frame_start = 0;
  endtask

  task automatic clear_inputs();
    frame_start = 0; line_end = 0; pixel_en = 0; pal_we = 0;
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < (1 << AW); i++) ram[i] = 16'($urandom);
    ram[0] = 16'h41F0;
    ram[1] = 16'h4251;
    ram[100] = 16'h5A31;

    // Reset held with random inputs
    for (int i = 0; i < 6; i++) begin
      frame_start = 1'($urandom); line_end = 1'($urandom); pixel_en = 1'($urandom);
      base_addr = AW'($urandom); pal_we = 1'($urandom); pal_addr = 4'($urandom);
      pal_data = 12'($urandom);
      cyc();
      check("rst_addr", ram_addr, 0);
    end
    clear_inputs();
    base_addr = '0;
    rst_n = 1;
    repeat (5) cyc();

    // First cells, row advance, column wrap
    frame(13'd0);
    px_run(16);
    repeat (4) cyc();
    repeat (8) line_pulse();
    px_run(1);
    repeat (4) cyc();
    line_pulse();
    px_run(COLS * 8 + 1);
    repeat (4) cyc();

    // Scroll wrap of the address space and row_base wrap after a full frame
    frame(13'h1FF0);
    px_run(20 * 8 + 1);
    repeat (4) cyc();
    for (int i = 0; i < ROWS * 8; i++) begin
      px_run(1);
      line_pulse();
    end
    px_run(2);
    repeat (4) cyc();

    // Palette write while a pixel using that index is in its RAM data cycle
    frame(13'd100);
    px_run(2);
    pal_we = 1; pal_addr = 4'd3; pal_data = 12'hA5C;
    cyc();
    pal_we = 0;
    repeat (4) cyc();

    // Collisions
    frame(13'd0);
    px_run(21);
    pixel_en = 1; line_end = 1;
    cyc();
    line_end = 0;
    px_run(3);
    pixel_en = 1; line_end = 1; frame_start = 1; base_addr = 13'd7;
    cyc();
    clear_inputs();
    px_run(3);
    repeat (4) cyc();

    // Randomized traffic
    for (int i = 0; i < 6000; i++) begin
      frame_start = ($urandom_range(999) < 3);
      line_end    = ($urandom_range(99) < 3);
      pixel_en    = ($urandom_range(9) < 8);
      pal_we      = ($urandom_range(19) == 0);
      pal_addr    = 4'($urandom);
      pal_data    = 12'($urandom);
      base_addr   = AW'($urandom);
      cyc();
    end
    clear_inputs();
    repeat (4) cyc();

    // Async reset while output is valid
    frame(13'd0);
    px_run(5);
    check("pre_rst_valid", valid, 1);
    #2;
    rst_n = 0;
    #1;
    check("async_valid", valid, 0);
    check("async_rd", ram_rd, 0);
    model_reset();
    repeat (2) cyc();
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      pixel_en = 1'($urandom);
      cyc();
    end
    pixel_en = 0;
    frame(13'd5);
    px_run(3);
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/text_cell_fetcher.md
# text_cell_fetcher

Text-mode cell sequencer that drives the character/colour inputs of the character blender. It tracks scan position in character-cell coordinates and fetches each cell's 16-bit entry (character code plus foreground/background palette indices) from a synchronous text RAM. It resolves both indices through an internal 16-entry 12-bit palette and presents, per active pixel, the character, glyph row/column and fg/bg colours with a fixed latency.

## Interface
Parameters:
- COLS, 80, text columns per row (cells are 8 pixels wide)
- ROWS, 60, text rows per frame (cells are 8 pixels tall)
- ADDR_W, 13, text RAM word-address width

Ports:
- i_clk  in  1  pixel clock
- i_rst_n  in  1  asynchronous active-low reset
- i_frame_start  in  1  one-cycle pulse before the first active line of a frame
- i_line_end  in  1  one-cycle pulse after the last active pixel of each line
- i_pixel_en  in  1  one active pixel this cycle
- i_base_addr  in  ADDR_W  text RAM address of cell (0,0); sampled on i_frame_start
- o_ram_rd  out  1  read strobe
- o_ram_addr  out  ADDR_W  cell word address
- i_ram_data  in  16  [15:8] char, [7:4] fg index, [3:0] bg index; valid the cycle after o_ram_rd
- i_pal_we  in  1  palette write strobe
- i_pal_addr  in  4  palette index to write
- i_pal_data  in  12  palette colour to write
- o_valid  out  1  outputs below describe one pixel
- o_char  out  8  character code
- o_row  out  3  glyph row within cell
- o_column  out  3  glyph column within cell
- o_fg_color  out  12  resolved foreground colour
- o_bg_color  out  12  resolved background colour

## Operation
- Counters: pix_col 0..7, cell_col 0..COLS-1, pix_row 0..7, cell_row 0..ROWS-1, row_base (ADDR_W), base (ADDR_W).
- i_frame_start: base <= i_base_addr, row_base <= i_base_addr, all counters <= 0.
- i_pixel_en: current cell address = row_base + cell_col (mod 2^ADDR_W). Stage 1 registers that address onto o_ram_addr with o_ram_rd=1 and carries pix_row/pix_col forward. pix_col then increments; wrapping 7->0 increments cell_col; cell_col wraps COLS-1->0.
- Every pixel issues a read, including repeats of the same address, so there is no prefetch state.
- i_line_end: pix_col, cell_col <= 0. pix_row increments. Wrap 7->0 increments cell_row and adds COLS to row_base. cell_row wrap ROWS-1->0 reloads row_base from base.
- Stage 2 (RAM data cycle): o_char <= data[15:8], o_fg_color <= pal[data[7:4]], o_bg_color <= pal[data[3:0]], o_row/o_column <= carried values, o_valid <= 1. With no pixel in the stage, o_valid <= 0 and the other outputs hold.
- Palette: 16 x 12-bit registers, written on i_pal_we at the clock edge. A lookup in the same cycle as a write to the same index returns the old value.
- Simultaneous events:
  - i_frame_start beats i_line_end.
  - i_pixel_en with i_line_end or i_frame_start: the pixel uses the pre-update counters, then the reset/advance applies.
- Address arithmetic wraps modulo 2^ADDR_W. No bounds check against RAM size.

## Timing
- Reset (async assert, registered deassert by the system): o_valid=0, o_ram_rd=0, o_ram_addr=0, o_char=0, o_row=0, o_column=0, o_fg_color=0, o_bg_color=0, all counters/base=0.
- Palette reset: entry k = {k,k,k}, e.g. 0->12'h000, 15->12'hFFF.
- Latency: i_pixel_en in cycle N gives o_ram_rd/o_ram_addr in N+1, i_ram_data in N+2, o_valid and data in N+3. Fixed, with full throughput (i_pixel_en may be high every cycle).
- Reset asserted mid-line drops o_valid and o_ram_rd immediately; in-flight pixels are discarded. After release, nothing is valid until the next i_frame_start plus i_pixel_en.
- Palette write in cycle N affects pixels whose RAM data arrives in N+1 or later.

## Test plan
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0. Release, no stimulus -> o_valid stays 0; palette reads give entry 5 = 12'h555.
- First cell: i_base_addr=0, frame_start, RAM[0]=16'h41F0, 8 consecutive i_pixel_en -> o_ram_addr=0 for 8 cycles starting N+1; o_valid from N+3 with o_char=8'h41, o_column 0..7, o_row=0, fg=12'hFFF, bg=12'h000.
- Cell/row advance: 9th pixel gives address 1. Eight i_line_end pulses give row 1 address 80. Pixel 640 of a line wraps cell_col to 0 (address row_base+0).
- Scroll and wrap: i_base_addr=13'h1FF0, COLS=80, cell_row 0 col 20 -> address 13'h0004. After 60 character rows, row_base returns to 13'h1FF0.
- Palette: write index 3 = 12'hA5C while a pixel with fg index 3 is in stage 2 -> that pixel shows 12'h333; the next pixel shows 12'hA5C.
- Collisions and reset: i_pixel_en + i_line_end + i_frame_start in one cycle -> pixel uses old counters, then all counters are 0. Async reset with o_valid=1 -> o_valid=0 before the next clock edge.
